// File: rtl/accel_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : accel_pair_scheduler
// Brief    : Issues all N x N body pairs to the acceleration pipeline, tags
//            each result with its row information and detects pass completion.
// Revision : 1.0 - initial release
// ============================================================================
module accel_pair_scheduler #(
    parameter int IDX_W   = 8,
    parameter int LATENCY = 123
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   n_bodies,
    input  logic             issue_en,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr_i,
    output logic [IDX_W-1:0] rd_addr_j,
    input  logic [63:0]      mem_xi,
    input  logic [63:0]      mem_yi,
    input  logic [63:0]      mem_xj,
    input  logic [63:0]      mem_yj,
    input  logic [63:0]      mem_mj,
    output logic             pipe_valid,
    output logic [63:0]      pipe_x1,
    output logic [63:0]      pipe_y1,
    output logic [63:0]      pipe_x2,
    output logic [63:0]      pipe_y2,
    output logic [63:0]      pipe_m2,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_body,
    output logic             out_first,
    output logic             out_last
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Tag layout: {valid, body_i, first_of_row, last_of_row}
    localparam int c_TAG_W = IDX_W + 3;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_n_m1;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic [IDX_W:0]     w_n_m1;
    logic [IDX_W+1:0]   r_inflight;
    logic               w_row_end;
    logic               w_last_pair;
    logic               w_drained;
    logic               w_accept;
    logic               r_done;
    logic [c_TAG_W-1:0] w_tag;
    logic [c_TAG_W-1:0] r_tag_rd;
    logic [c_TAG_W-1:0] r_tag_pipe;
    logic [c_TAG_W-1:0] r_tag_sr [LATENCY];

    assign w_n_m1      = n_bodies - 1'b1;
    assign w_row_end   = (r_j == r_n_m1);
    assign w_last_pair = w_row_end && (r_i == r_n_m1);
    assign w_accept    = (r_state == S_IDLE) && start && (n_bodies != '0);
    // The final result may retire in the same cycle the check is made.
    assign w_drained   = (r_inflight == '0) ||
                         ((r_inflight == (IDX_W+2)'(1)) && out_valid);
    assign w_tag       = {rd_en, r_i, (r_j == '0), w_row_end};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (n_bodies == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy  = 1'b1;
                rd_en = issue_en;
                if (issue_en && w_last_pair) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                busy        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n_m1 <= '0;
            r_i    <= '0;
            r_j    <= '0;
        end else if (w_accept) begin
            r_n_m1 <= w_n_m1[IDX_W-1:0];
            r_i    <= '0;
            r_j    <= '0;
        end else if (rd_en) begin
            if (w_row_end) begin
                r_j <= '0;
                r_i <= w_last_pair ? '0 : r_i + 1'b1;
            end else begin
                r_j <= r_j + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({rd_en, out_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH);
        end
    end

    // Operands are captured the cycle memory data is valid and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_rd   <= '0;
            r_tag_pipe <= '0;
            pipe_x1    <= '0;
            pipe_y1    <= '0;
            pipe_x2    <= '0;
            pipe_y2    <= '0;
            pipe_m2    <= '0;
        end else begin
            r_tag_rd   <= w_tag;
            r_tag_pipe <= r_tag_rd;
            if (r_tag_rd[c_TAG_W-1]) begin
                pipe_x1 <= mem_xi;
                pipe_y1 <= mem_yi;
                pipe_x2 <= mem_xj;
                pipe_y2 <= mem_yj;
                pipe_m2 <= mem_mj;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_tag_sr[k] <= '0;
            end
        end else begin
            r_tag_sr[0] <= r_tag_pipe;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag_sr[k] <= r_tag_sr[k-1];
            end
        end
    end

    assign done       = r_done;
    assign rd_addr_i  = r_i;
    assign rd_addr_j  = r_j;
    assign pipe_valid = r_tag_pipe[c_TAG_W-1];
    assign out_valid  = r_tag_sr[LATENCY-1][c_TAG_W-1];
    assign out_body   = r_tag_sr[LATENCY-1][IDX_W+1:2];
    assign out_first  = r_tag_sr[LATENCY-1][1];
    assign out_last   = r_tag_sr[LATENCY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_accel_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_pair_scheduler
// Brief    : Directed self-checking bench for accel_pair_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accel_pair_scheduler;

    localparam int IDX_W     = 8;
    localparam int LAT       = 123;
    localparam int c_EXP_LAT = 125;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [IDX_W:0]   n_bodies = '0;
    logic             issue_en = 1'b1;
    logic             busy, done, rd_en;
    logic [IDX_W-1:0] rd_addr_i, rd_addr_j;
    logic [63:0]      mem_xi, mem_yi, mem_xj, mem_yj, mem_mj;
    logic             pipe_valid;
    logic [63:0]      pipe_x1, pipe_y1, pipe_x2, pipe_y2, pipe_m2;
    logic             out_valid;
    logic [IDX_W-1:0] out_body;
    logic             out_first, out_last;

    accel_pair_scheduler #(.IDX_W(IDX_W), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .n_bodies(n_bodies),
        .issue_en(issue_en), .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j),
        .mem_xi(mem_xi), .mem_yi(mem_yi), .mem_xj(mem_xj),
        .mem_yj(mem_yj), .mem_mj(mem_mj), .pipe_valid(pipe_valid),
        .pipe_x1(pipe_x1), .pipe_y1(pipe_y1), .pipe_x2(pipe_x2),
        .pipe_y2(pipe_y2), .pipe_m2(pipe_m2), .out_valid(out_valid),
        .out_body(out_body), .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Body memory: one-cycle read latency, contents derived from the address.
    logic [IDX_W-1:0] ma_i = '0, ma_j = '0;
    always @(posedge clk) begin
        ma_i <= rd_addr_i;
        ma_j <= rd_addr_j;
    end
    assign mem_xi = {16'h1111, 40'h0, ma_i};
    assign mem_yi = {16'h2222, 40'h0, ma_i};
    assign mem_xj = {16'h3333, 40'h0, ma_j};
    assign mem_yj = {16'h4444, 40'h0, ma_j};
    assign mem_mj = {16'h5555, 40'h0, ma_j};

    function automatic logic [63:0] pat(input logic [15:0] p, input int idx);
        return {p, 40'h0, IDX_W'(idx)};
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {int c; int i; int j; int n;} rd_t;
    rd_t pq[$];
    rd_t oq[$];
    int model_n = 0;
    int exp_i = 0, exp_j = 0;
    int n_rd = 0, n_out = 0, n_first = 0, n_last = 0, n_done = 0, n_busy = 0;
    int last_i = -1, last_j = -1;
    logic [63:0] hold_x1 = '0, hold_m2 = '0;

    always @(negedge clk) begin
        rd_t e;
        if (out_valid) begin
            if (oq.size() == 0) begin
                check("out_spurious", 64'(out_valid), 64'(0));
            end else begin
                e = oq.pop_front();
                check("out_body", 64'(out_body), 64'(e.i));
                check("out_first", 64'(out_first), 64'(e.j == 0));
                check("out_last", 64'(out_last), 64'(e.j == e.n - 1));
                check("out_lat", 64'(cyc - e.c), 64'(c_EXP_LAT));
            end
            n_out++;
            if (out_first) n_first++;
            if (out_last) n_last++;
        end
        if (pipe_valid) begin
            if (pq.size() == 0) begin
                check("pipe_spurious", 64'(pipe_valid), 64'(0));
            end else begin
                e = pq.pop_front();
                check("pipe_x1", pipe_x1, pat(16'h1111, e.i));
                check("pipe_y1", pipe_y1, pat(16'h2222, e.i));
                check("pipe_x2", pipe_x2, pat(16'h3333, e.j));
                check("pipe_y2", pipe_y2, pat(16'h4444, e.j));
                check("pipe_m2", pipe_m2, pat(16'h5555, e.j));
                check("pipe_lat", 64'(cyc - e.c), 64'(2));
            end
            hold_x1 = pipe_x1;
            hold_m2 = pipe_m2;
        end else if (busy) begin
            check("hold_x1", pipe_x1, hold_x1);
            check("hold_m2", pipe_m2, hold_m2);
        end
        if (rd_en) begin
            check("rd_i", 64'(rd_addr_i), 64'(exp_i));
            check("rd_j", 64'(rd_addr_j), 64'(exp_j));
            e = '{cyc, exp_i, exp_j, model_n};
            pq.push_back(e);
            oq.push_back(e);
            n_rd++;
            last_i = int'(rd_addr_i);
            last_j = int'(rd_addr_j);
            if (exp_j == model_n - 1) begin
                exp_j = 0;
                exp_i++;
            end else begin
                exp_j++;
            end
        end
        if (done) n_done++;
        if (busy) n_busy++;
        if (rst) begin
            pq.delete();
            oq.delete();
            exp_i = 0;
            exp_j = 0;
            hold_x1 = '0;
            hold_m2 = '0;
        end else if (!busy) begin
            exp_i = 0;
            exp_j = 0;
        end
    end

    // One pass: start with n, optional 1/0 issue_en toggling, optional
    // ignored start pulse (with a different N) at loop index inj.
    task automatic run_pass(input int n, input bit tog, input int inj,
                            input int exp_dly, input int exp_busy);
        int rd0, out0, first0, last0, done0, busy0, t0, dcyc;
        rd0 = n_rd; out0 = n_out; first0 = n_first; last0 = n_last;
        done0 = n_done; busy0 = n_busy; dcyc = -1;
        @(posedge clk); #1;
        start = 1'b1; n_bodies = (IDX_W+1)'(n); model_n = n; issue_en = 1'b1; t0 = cyc;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
        for (int k = 0; k < 70000 && dcyc < 0; k++) begin
            @(posedge clk); #1;
            start    = (k == inj);
            n_bodies = (IDX_W+1)'(7);
            issue_en = tog ? (k % 2 == 0) : 1'b1;
            @(negedge clk);
            if (done) dcyc = cyc;
        end
        start = 1'b0;
        issue_en = 1'b1;
        #2;
        if (dcyc < 0) check("timeout", 64'(0), 64'(1));
        else          check("done_dly", 64'(dcyc - t0), 64'(exp_dly));
        check("busy_cyc", 64'(n_busy - busy0), 64'(exp_busy));
        check("n_rd", 64'(n_rd - rd0), 64'(n * n));
        check("n_out", 64'(n_out - out0), 64'(n * n));
        check("n_first", 64'(n_first - first0), 64'(n));
        check("n_last", 64'(n_last - last0), 64'(n));
        check("n_done", 64'(n_done - done0), 64'(1));
    endtask

    initial begin
        int rd0, out0, done0;
        bit hit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rd_en", 64'(rd_en), 64'(0));
        check("rst_pipe_valid", 64'(pipe_valid), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_pipe_x1", pipe_x1, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        run_pass(3, 1'b0, 3, 136, 135);
        run_pass(2, 1'b0, -1, 131, 130);
        run_pass(0, 1'b0, -1, 2, 1);
        run_pass(4, 1'b1, -1, 158, 157);

        // Reset in the middle of an N=8 pass
        rd0 = n_rd;
        @(posedge clk); #1;
        start = 1'b1; n_bodies = (IDX_W+1)'(8); model_n = 8;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk); #1;
            if (n_rd - rd0 >= 20) hit = 1'b1;
        end
        check("mid_rst_reach", 64'(hit), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_done", 64'(done), 64'(0));
        check("mr_rd_en", 64'(rd_en), 64'(0));
        check("mr_rd_addr", 64'({rd_addr_i, rd_addr_j}), 64'(0));
        check("mr_pipe_valid", 64'(pipe_valid), 64'(0));
        check("mr_pipe_x1", pipe_x1, 64'(0));
        check("mr_out", 64'({out_valid, out_body, out_first, out_last}), 64'(0));
        out0 = n_out; done0 = n_done;
        repeat (LAT + 5) @(negedge clk);
        #1;
        check("mr_stale_out", 64'(n_out - out0), 64'(0));
        check("mr_no_done", 64'(n_done - done0), 64'(0));
        run_pass(2, 1'b0, -1, 131, 130);

        run_pass(256, 1'b0, -1, 65663, 65662);
        check("last_rd_i", 64'(last_i), 64'(255));
        check("last_rd_j", 64'(last_j), 64'(255));
        @(negedge clk);
        check("done_end", 64'(done), 64'(0));
        check("busy_end", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
